// File: rtl/obuf_sso_sequencer.sv
// Staggered output-enable sequencer for pad buffer groups: enables groups one at a
// time with programmable spacing, disables them in reverse, and gates pad data.
module obuf_sso_sequencer #(
    parameter int unsigned    GROUPS   = 4,
    parameter int unsigned    W        = 8,
    parameter int unsigned    DLY_W    = 16,
    parameter logic [W-1:0]   SAFE_VAL = '0
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_en_req,
    input  logic [DLY_W-1:0]      i_dly,
    input  logic [GROUPS*W-1:0]   i_pad_data,
    output logic [GROUPS-1:0]     o_grp_oe,
    output logic [GROUPS*W-1:0]   o_pad_data,
    output logic                  o_ready,
    output logic                  o_off,
    output logic                  o_busy
);

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        ON,
        RAMP_DOWN
    } state_t;

    localparam logic [GROUPS-1:0] GRP_FIRST = GROUPS'(1);
    localparam logic [GROUPS-1:0] GRP_ALL   = '1;
    localparam logic [DLY_W-1:0]  DLY_ONE   = DLY_W'(1);

    state_t              state;
    state_t              state_n;
    logic [GROUPS-1:0]   oe_n;
    logic [DLY_W-1:0]    cnt;
    logic [DLY_W-1:0]    cnt_n;
    logic [DLY_W-1:0]    dly_q;
    logic [DLY_W-1:0]    dly_n;
    logic [DLY_W-1:0]    step_q;
    logic [DLY_W-1:0]    step_in;
    logic [GROUPS*W-1:0] pad_n;

    // A spacing of 0 behaves as 1 so two switch events always land on distinct edges.
    always_comb begin
        step_q  = (dly_q == '0) ? DLY_ONE : dly_q;
        step_in = (i_dly == '0) ? DLY_ONE : i_dly;
    end

    always_comb begin
        state_n = state;
        oe_n    = o_grp_oe;
        cnt_n   = cnt;
        dly_n   = dly_q;
        case (state)
            IDLE: begin
                if (i_en_req) begin
                    dly_n   = i_dly;
                    oe_n    = GRP_FIRST;
                    cnt_n   = step_in - DLY_ONE;
                    state_n = (GROUPS == 1) ? ON : RAMP_UP;
                end
            end
            RAMP_UP: begin
                // A reversal keeps the enables and restarts the spacing with the latched step.
                if (!i_en_req) begin
                    state_n = RAMP_DOWN;
                    cnt_n   = step_q - DLY_ONE;
                end else if (cnt == '0) begin
                    oe_n  = (o_grp_oe << 1) | GRP_FIRST;
                    cnt_n = step_q - DLY_ONE;
                    if (oe_n[GROUPS-1]) begin
                        state_n = ON;
                    end
                end else begin
                    cnt_n = cnt - DLY_ONE;
                end
            end
            ON: begin
                oe_n = GRP_ALL;
                if (!i_en_req) begin
                    dly_n   = i_dly;
                    oe_n    = GRP_ALL >> 1;
                    cnt_n   = step_in - DLY_ONE;
                    state_n = (GROUPS == 1) ? IDLE : RAMP_DOWN;
                end
            end
            RAMP_DOWN: begin
                if (i_en_req) begin
                    state_n = RAMP_UP;
                    cnt_n   = step_q - DLY_ONE;
                end else if (cnt == '0) begin
                    oe_n  = o_grp_oe >> 1;
                    cnt_n = step_q - DLY_ONE;
                    if (!oe_n[0]) begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - DLY_ONE;
                end
            end
            default: begin
                state_n = IDLE;
                oe_n    = '0;
                cnt_n   = '0;
            end
        endcase
    end

    // Data follows the next-cycle enable so data and enable of a group change together.
    always_comb begin
        pad_n = '0;
        for (int unsigned g = 0; g < GROUPS; g++) begin
            pad_n[g*W +: W] = oe_n[g] ? i_pad_data[g*W +: W] : SAFE_VAL;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state      <= IDLE;
            o_grp_oe   <= '0;
            cnt        <= '0;
            dly_q      <= '0;
            o_pad_data <= {GROUPS{SAFE_VAL}};
            o_ready    <= 1'b0;
            o_off      <= 1'b1;
            o_busy     <= 1'b0;
        end else begin
            state      <= state_n;
            o_grp_oe   <= oe_n;
            cnt        <= cnt_n;
            dly_q      <= dly_n;
            o_pad_data <= pad_n;
            o_ready    <= (state_n == ON);
            o_off      <= (state_n == IDLE);
            o_busy     <= (state_n == RAMP_UP) || (state_n == RAMP_DOWN);
        end
    end

endmodule

// File: tb/tb_obuf_sso_sequencer.sv
// Bench for obuf_sso_sequencer: directed scenarios plus a randomized run against an
// event-timestamp model (count of enabled groups, cycle of the last switch event).
module tb_obuf_sso_sequencer;

    localparam int G  = 4;
    localparam int W  = 8;
    localparam int DW = 16;

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_ON   = 2;
    localparam int M_DOWN = 3;

    logic            clk;
    logic            nrst;
    logic            en_req;
    logic [DW-1:0]   dly;
    logic [G*W-1:0]  pad_in;
    logic [G-1:0]    grp_oe;
    logic [G*W-1:0]  pad_out;
    logic            ready;
    logic            off;
    logic            busy;

    int checks;
    int failures;

    // Reference model state
    int             m_mode;
    int             m_k;
    longint         cyc;
    longint         last_evt;
    longint         m_step;
    logic [G*W-1:0] m_pad;

    obuf_sso_sequencer #(
        .GROUPS   (G),
        .W        (W),
        .DLY_W    (DW),
        .SAFE_VAL (8'h00)
    ) dut (
        .i_clk      (clk),
        .i_nrst     (nrst),
        .i_en_req   (en_req),
        .i_dly      (dly),
        .i_pad_data (pad_in),
        .o_grp_oe   (grp_oe),
        .o_pad_data (pad_out),
        .o_ready    (ready),
        .o_off      (off),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_update();
        cyc++;
        if (!nrst) begin
            m_mode = M_IDLE;
            m_k    = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (en_req) begin
                    m_step   = (dly == 0) ? 1 : longint'(dly);
                    m_k      = 1;
                    last_evt = cyc;
                    m_mode   = (G == 1) ? M_ON : M_UP;
                end
                M_UP: if (!en_req) begin
                    m_mode   = M_DOWN;
                    last_evt = cyc;
                end else if (cyc - last_evt >= m_step) begin
                    m_k++;
                    last_evt = cyc;
                    if (m_k == G) m_mode = M_ON;
                end
                M_ON: if (!en_req) begin
                    m_step   = (dly == 0) ? 1 : longint'(dly);
                    m_k--;
                    last_evt = cyc;
                    m_mode   = (m_k == 0) ? M_IDLE : M_DOWN;
                end
                default: if (en_req) begin
                    m_mode   = M_UP;
                    last_evt = cyc;
                end else if (cyc - last_evt >= m_step) begin
                    m_k--;
                    last_evt = cyc;
                    if (m_k == 0) m_mode = M_IDLE;
                end
            endcase
        end
        for (int g = 0; g < G; g++) begin
            m_pad[g*W +: W] = (g < m_k) ? pad_in[g*W +: W] : 8'h00;
        end
    endtask

    // Advance one clock edge; inputs are stable from the previous negedge.
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        tick();
        tick();
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        nrst   = 1'b0;
        en_req = 1'b1;
        pad_in = '1;
        dly    = 16'd3;
        tick();
        tick();
        checks++;
        if (grp_oe !== 4'b0000) begin
            failures++;
            $display("FAIL reset_oe got=%b exp=0000", grp_oe);
        end
        checks++;
        if (pad_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_pad got=%h exp=00000000", pad_out);
        end
        checks++;
        if ({off, busy, ready} !== 3'b100) begin
            failures++;
            $display("FAIL reset_status got off/busy/ready=%b exp=100", {off, busy, ready});
        end
        en_req = 1'b0;
        nrst   = 1'b1;
        tick();
    endtask

    task automatic test_ramp_up();
        logic [G-1:0] exp_oe;
        do_reset();
        dly    = 16'd3;
        en_req = 1'b1;
        for (int e = 0; e <= 9; e++) begin
            tick();
            exp_oe = (e < 3) ? 4'b0001 : (e < 6) ? 4'b0011 : (e < 9) ? 4'b0111 : 4'b1111;
            checks++;
            if (grp_oe !== exp_oe) begin
                failures++;
                $display("FAIL ramp_up_oe edge=%0d got=%b exp=%b", e, grp_oe, exp_oe);
            end
            checks++;
            if ({busy, ready, off} !== ((e < 9) ? 3'b100 : 3'b010)) begin
                failures++;
                $display("FAIL ramp_up_status edge=%0d got busy/ready/off=%b exp=%b",
                         e, {busy, ready, off}, (e < 9) ? 3'b100 : 3'b010);
            end
        end
    endtask

    task automatic test_ramp_down();
        logic [G-1:0] exp_oe;
        do_reset();
        dly    = 16'd0;
        en_req = 1'b1;
        repeat (5) tick();
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL ramp_down_pre_on got ready=%b exp=1", ready);
        end
        dly    = 16'd2;
        en_req = 1'b0;
        for (int j = 0; j <= 6; j++) begin
            tick();
            exp_oe = (j < 2) ? 4'b0111 : (j < 4) ? 4'b0011 : (j < 6) ? 4'b0001 : 4'b0000;
            checks++;
            if (grp_oe !== exp_oe) begin
                failures++;
                $display("FAIL ramp_down_oe k+%0d got=%b exp=%b", j, grp_oe, exp_oe);
            end
        end
        checks++;
        if ({off, busy} !== 2'b10) begin
            failures++;
            $display("FAIL ramp_down_off got off/busy=%b exp=10", {off, busy});
        end
    endtask

    task automatic test_reversal();
        logic [G-1:0] exp_oe;
        do_reset();
        dly    = 16'd4;
        en_req = 1'b1;
        tick();
        dly = 16'd1;
        repeat (4) tick();
        checks++;
        if (grp_oe !== 4'b0011) begin
            failures++;
            $display("FAIL reversal_pre got=%b exp=0011", grp_oe);
        end
        en_req = 1'b0;
        for (int j = 5; j <= 13; j++) begin
            tick();
            exp_oe = (j < 9) ? 4'b0011 : (j < 13) ? 4'b0001 : 4'b0000;
            checks++;
            if (grp_oe !== exp_oe) begin
                failures++;
                $display("FAIL reversal_oe edge=%0d got=%b exp=%b", j, grp_oe, exp_oe);
            end
        end
        checks++;
        if (off !== 1'b1) begin
            failures++;
            $display("FAIL reversal_off got=%b exp=1", off);
        end
    endtask

    task automatic test_dly_zero();
        logic [G-1:0] exp_oe;
        do_reset();
        dly    = 16'd0;
        en_req = 1'b1;
        for (int e = 0; e < 4; e++) begin
            tick();
            exp_oe = G'((1 << (e + 1)) - 1);
            checks++;
            if (grp_oe !== exp_oe) begin
                failures++;
                $display("FAIL dly_zero_oe edge=%0d got=%b exp=%b", e, grp_oe, exp_oe);
            end
        end
    endtask

    task automatic test_data_gating();
        logic [G*W-1:0] exp_pad;
        do_reset();
        pad_in = {G{8'hA5}};
        dly    = 16'd2;
        en_req = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            tick();
            for (int g = 0; g < G; g++) begin
                exp_pad[g*W +: W] = (g <= e / 2) ? 8'hA5 : 8'h00;
            end
            checks++;
            if (pad_out !== exp_pad) begin
                failures++;
                $display("FAIL gating_pad edge=%0d got=%h exp=%h oe=%b", e, pad_out, exp_pad, grp_oe);
            end
        end
        pad_in = 32'h3C5A_9612;
        #1;
        checks++;
        if (pad_out !== {G{8'hA5}}) begin
            failures++;
            $display("FAIL gating_hold got=%h exp=%h", pad_out, {G{8'hA5}});
        end
        tick();
        checks++;
        if (pad_out !== 32'h3C5A_9612) begin
            failures++;
            $display("FAIL gating_update got=%h exp=3c5a9612", pad_out);
        end
    endtask

    task automatic test_random();
        logic [G-1:0] exp_oe;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) en_req = ~en_req;
            if ($urandom_range(0, 15) == 0) dly = 16'($urandom_range(0, 3));
            pad_in = $urandom;
            nrst   = ($urandom_range(0, 149) != 0);
            tick();
            exp_oe = G'((1 << m_k) - 1);
            checks++;
            if (grp_oe !== exp_oe) begin
                failures++;
                $display("FAIL random_oe cyc=%0d got=%b exp=%b", i, grp_oe, exp_oe);
            end
            checks++;
            if (pad_out !== m_pad) begin
                failures++;
                $display("FAIL random_pad cyc=%0d got=%h exp=%h", i, pad_out, m_pad);
            end
            checks++;
            if ({ready, off, busy} !== {m_mode == M_ON, m_mode == M_IDLE,
                                        m_mode == M_UP || m_mode == M_DOWN}) begin
                failures++;
                $display("FAIL random_status cyc=%0d got ready/off/busy=%b mode=%0d",
                         i, {ready, off, busy}, m_mode);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        last_evt = 0;
        m_step   = 1;
        m_mode   = M_IDLE;
        m_k      = 0;
        m_pad    = '0;
        nrst     = 1'b0;
        en_req   = 1'b0;
        dly      = '0;
        pad_in   = '0;
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_reversal();
        test_dly_zero();
        test_data_gating();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/obuf_sso_sequencer.md
Name: obuf_sso_sequencer

Overview:
Staggered output-enable controller for groups of output pad buffers. It limits simultaneous-switching noise by enabling pad groups one at a time with a programmable spacing, then disabling them in reverse order. It also registers per-group pad data and forces disabled groups to a safe level. It sits between the SoC I/O logic and the per-pin output buffer instances.

Parameters:
GROUPS, 4, number of pad groups sequenced; minimum 1.
W, 8, data bits per group.
DLY_W, 16, width of the spacing input.
SAFE_VAL, 0, W-bit value driven on disabled groups.

Ports:
i_clk  input  1  clock; all logic is on the rising edge.
i_nrst  input  1  synchronous reset, active-low.
i_en_req  input  1  level request: 1 means all groups on, 0 means all groups off.
i_dly  input  DLY_W  spacing in cycles between consecutive group switch events; 0 is treated as 1.
i_pad_data  input  GROUPS*W  pad data; group g is bits [g*W+W-1 : g*W].
o_grp_oe  output  GROUPS  per-group output enable to the pad buffers.
o_pad_data  output  GROUPS*W  registered pad data to the output buffers.
o_ready  output  1  high in state ON.
o_off  output  1  high in state IDLE.
o_busy  output  1  high in RAMP_UP or RAMP_DOWN.

Behaviour:
- Reset (i_nrst=0 at a clock edge):
  - state=IDLE, o_grp_oe=0, o_pad_data=all groups SAFE_VAL.
  - step counter=0, group index=0.
  - o_off=1, o_ready=0, o_busy=0.
  - Reset mid-ramp drops all enables on that same edge. There is no ramp-down on reset.
- step = (latched dly==0) ? 1 : latched dly.
  - dly is latched from i_dly only on the IDLE->RAMP_UP and ON->RAMP_DOWN transitions.
  - It is not re-sampled on a ramp reversal.
- Counter: DLY_W bits. Loaded with step-1 at each switch event or reversal. Decrements by 1 per cycle in ramp states and saturates at 0.
- State IDLE:
  - Sampled i_en_req=1 -> RAMP_UP.
  - On the same edge: o_grp_oe[0]=1, counter=step-1.
  - If GROUPS==1, go directly to ON instead.
- State RAMP_UP:
  - When counter==0: set the next higher group's enable and reload the counter.
  - Setting the top group GROUPS-1 moves to ON on the same edge.
  - Sampled i_en_req=0 -> RAMP_DOWN. o_grp_oe is unchanged, counter reloads to step-1, and the first clear happens when the counter next reaches 0.
  - Consequence: two switch events are never closer than step cycles.
- State ON:
  - o_grp_oe all ones.
  - Sampled i_en_req=0 -> RAMP_DOWN.
  - On the same edge: the highest group is cleared and counter=step-1.
  - If GROUPS==1, go directly to IDLE instead.
- State RAMP_DOWN:
  - When counter==0: clear the highest enabled group and reload the counter.
  - Clearing group 0 moves to IDLE on the same edge.
  - Sampled i_en_req=1 -> RAMP_UP, with the symmetric reversal rule: enables unchanged, counter reloaded, next enable when the counter reaches 0.
- Invariant: o_grp_oe is always thermometer-coded from bit 0 (0…01…1).
- Status outputs are decoded from the registered state, so they align with o_grp_oe.
- Pad data path, one-cycle latency:
  - o_pad_data group g <= o_grp_oe_next[g] ? i_pad_data group g : SAFE_VAL.
  - Data and enable for a group change on the same edge.
- i_en_req toggling faster than step: only reversals apply. No state is skipped and enables never jump by more than one group per event.

Test Plan:
- Reset: hold i_nrst=0 for 2 cycles with i_en_req=1 and i_pad_data all 0xFF -> o_grp_oe=0000, o_pad_data all 0x00, o_off=1, o_busy=0.
- Ramp up (GROUPS=4, i_dly=3, i_en_req rises, sampled at edge 0):
  - o_grp_oe=0001 at edge 0, 0011 at 3, 0111 at 6, 1111 at 9.
  - o_ready=1 from edge 9; o_busy=1 on edges 0–8.
- Ramp down from ON (i_dly=2, i_en_req=0 sampled at edge k):
  - o_grp_oe=0111 at k, 0011 at k+2, 0001 at k+4, 0000 at k+6.
  - o_off=1 at k+6.
- Reversal (i_dly=4): drop i_en_req one cycle after o_grp_oe becomes 0011 -> no change for 4 cycles, then 0001, then 0000 four cycles later. i_dly changed mid-ramp is ignored.
- i_dly=0 -> behaves as step 1: 0001, 0011, 0111, 1111 on consecutive edges.
- Data gating: i_pad_data=0xA5 in every group during ramp up -> o_pad_data group g reads 0xA5 exactly when o_grp_oe[g]=1, else 0x00. The value updates one cycle after an input data change.
